data_beat_packer: RTL and testbench

DATA_BEAT_PACKER -- requirements
Module: data_beat_packer

---
 rtl/data_beat_packer.sv | 107 ++++++++++
 tb/tb_data_beat_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_beat_packer.sv
// Packs RATIO narrow DSIZE beats into one word; the word appears one cycle after its completing beat is accepted.
// Backpressure: input is stalled only while a word is held and downstream is not ready. Define DATA_BEAT_PACKER_LAST_EN to let from_up_last close short words.
module data_beat_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     from_up_vld,
    input  logic [DSIZE-1:0]         from_up_data,
    input  logic                     from_up_last,
    output logic                     to_up_ready,
    input  logic                     from_down_ready,
    output logic                     to_down_vld,
    output logic [DSIZE*RATIO-1:0]   to_down_data,
    output logic [RATIO-1:0]         to_down_keep,
    output logic                     to_down_last
);

    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);

    logic [CW-1:0]          cnt_q,  cnt_d;
    logic [DSIZE*RATIO-1:0] acc_q,  acc_d;
    logic                   vld_q,  vld_d;
    logic [DSIZE*RATIO-1:0] data_q, data_d;
    logic [RATIO-1:0]       keep_q, keep_d;
    logic                   last_q, last_d;

    logic                   last_in;
    logic                   accept;
    logic                   complete;
    logic [DSIZE*RATIO-1:0] acc_with_beat;
    logic [RATIO-1:0]       keep_mask;

`ifdef DATA_BEAT_PACKER_LAST_EN
    assign last_in = from_up_last;
`else
    // Port stays on the interface but has no effect in this build.
    assign last_in = from_up_last & 1'b0;
`endif

    assign to_up_ready = !rst && (!vld_q || from_down_ready);
    assign accept      = from_up_vld && to_up_ready;
    assign complete    = accept && ((cnt_q == LAST_SLOT) || last_in);

    always_comb begin
        acc_with_beat = acc_q;
        keep_mask     = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) == cnt_q) begin
                acc_with_beat[i*DSIZE +: DSIZE] = from_up_data;
            end
            keep_mask[i] = (CW'(i) <= cnt_q);
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        vld_d  = vld_q;
        data_d = data_q;
        keep_d = keep_q;
        last_d = last_q;

        if (vld_q && from_down_ready) begin
            vld_d = 1'b0;
        end

        if (complete) begin
            // Accumulator is zero above cnt, so unused slots leave as zero.
            data_d = acc_with_beat;
            keep_d = keep_mask;
            last_d = last_in;
            vld_d  = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
        end else if (accept) begin
            acc_d  = acc_with_beat;
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            vld_q  <= vld_d;
            data_q <= data_d;
            keep_q <= keep_d;
            last_q <= last_d;
        end
    end

    assign to_down_vld  = vld_q;
    assign to_down_data = data_q;
    assign to_down_keep = keep_q;
    assign to_down_last = last_q;

endmodule

// File: tb/tb_data_beat_packer.sv
// Directed bench for data_beat_packer at DSIZE=8, RATIO=4; follows DATA_BEAT_PACKER_LAST_EN like the DUT.
module tb_data_beat_packer;

    logic        clock = 1'b0;
    logic        rst;
    logic        from_up_vld;
    logic [7:0]  from_up_data;
    logic        from_up_last;
    logic        to_up_ready;
    logic        from_down_ready;
    logic        to_down_vld;
    logic [31:0] to_down_data;
    logic [3:0]  to_down_keep;
    logic        to_down_last;

    int vecs = 0;
    int errs = 0;

    data_beat_packer #(.DSIZE(8), .RATIO(4)) dut (
        .clock           (clock),
        .rst             (rst),
        .from_up_vld     (from_up_vld),
        .from_up_data    (from_up_data),
        .from_up_last    (from_up_last),
        .to_up_ready     (to_up_ready),
        .from_down_ready (from_down_ready),
        .to_down_vld     (to_down_vld),
        .to_down_data    (to_down_data),
        .to_down_keep    (to_down_keep),
        .to_down_last    (to_down_last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one beat for a single clock edge; valid stays high afterwards.
    task automatic beat(input logic [7:0] d, input logic l);
        from_up_vld  = 1'b1;
        from_up_data = d;
        from_up_last = l;
        step();
    endtask

    task automatic idle();
        from_up_vld  = 1'b0;
        from_up_last = 1'b0;
        step();
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        chk({tag, ".vld"},  {31'b0, to_down_vld}, 32'd1);
        chk({tag, ".data"}, to_down_data, d);
        chk({tag, ".keep"}, {28'b0, to_down_keep}, {28'b0, k});
        chk({tag, ".last"}, {31'b0, to_down_last}, {31'b0, l});
    endtask

    initial begin
        rst             = 1'b1;
        from_up_vld     = 1'b0;
        from_up_data    = 8'h00;
        from_up_last    = 1'b0;
        from_down_ready = 1'b1;
        step();
        from_up_vld = 1'b1;
        step();
        chk("rst.ready", {31'b0, to_up_ready}, 32'd0);
        chk("rst.vld",   {31'b0, to_down_vld}, 32'd0);
        chk("rst.data",  to_down_data, 32'd0);
        chk("rst.keep",  {28'b0, to_down_keep}, 32'd0);
        chk("rst.last",  {31'b0, to_down_last}, 32'd0);
        from_up_vld = 1'b0;
        rst = 1'b0;
        step();

        // Full word with downstream ready.
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        chk("w1.early_vld", {31'b0, to_down_vld}, 32'd0);
        beat(8'h44, 1'b0);
        chk_word("w1", 32'h44332211, 4'b1111, 1'b0);

        // Hold the word under backpressure while a new beat is offered.
        from_down_ready = 1'b0;
        from_up_vld     = 1'b1;
        from_up_data    = 8'hC1;
        from_up_last    = 1'b0;
        #1;
        chk("stall.ready0", {31'b0, to_up_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall.ready", {31'b0, to_up_ready}, 32'd0);
            chk_word("stall", 32'h44332211, 4'b1111, 1'b0);
        end
        from_down_ready = 1'b1;
        #1;
        chk("release.ready", {31'b0, to_up_ready}, 32'd1);
        step();
        chk("release.vld", {31'b0, to_down_vld}, 32'd0);
        beat(8'hC2, 1'b0);
        beat(8'hC3, 1'b0);
        beat(8'hC4, 1'b0);
        chk_word("w2", 32'hC4C3C2C1, 4'b1111, 1'b0);
        idle();
        chk("w2.drain", {31'b0, to_down_vld}, 32'd0);

`ifdef DATA_BEAT_PACKER_LAST_EN
        // Short packet, then confirm the next beat starts at slot 0.
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b1);
        chk_word("short", 32'h0000A2A1, 4'b0011, 1'b1);
        beat(8'hE1, 1'b0);
        beat(8'hE2, 1'b0);
        beat(8'hE3, 1'b0);
        beat(8'hE4, 1'b1);
        chk_word("last_full", 32'hE4E3E2E1, 4'b1111, 1'b1);
        idle();
        chk("last_full.single", {31'b0, to_down_vld}, 32'd0);

        // Back-to-back single-beat packets: no bubble between words.
        beat(8'hD1, 1'b1);
        chk_word("b2b1", 32'h000000D1, 4'b0001, 1'b1);
        beat(8'hD2, 1'b1);
        chk_word("b2b2", 32'h000000D2, 4'b0001, 1'b1);
        idle();
        chk("b2b.drain", {31'b0, to_down_vld}, 32'd0);
`else
        // Last is ignored: the word closes only at the fourth beat.
        beat(8'hB1, 1'b0);
        beat(8'hB2, 1'b1);
        chk("nolast.vld", {31'b0, to_down_vld}, 32'd0);
        beat(8'hB3, 1'b0);
        beat(8'hB4, 1'b1);
        chk_word("nolast", 32'hB4B3B2B1, 4'b1111, 1'b0);
        idle();
`endif

        // Sixteen beats at full rate.
        for (int i = 1; i <= 16; i++) begin
            beat(8'(i), 1'b0);
            chk("stream.ready", {31'b0, to_up_ready}, 32'd1);
            chk("stream.vld", {31'b0, to_down_vld}, {31'b0, (i % 4) == 0});
            if ((i % 4) == 0) begin
                chk("stream.data", to_down_data, {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
            end
        end
        idle();

        // Reset mid-word discards the partial accumulation.
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        from_up_vld = 1'b0;
        rst = 1'b1;
        step();
        chk("midrst.ready", {31'b0, to_up_ready}, 32'd0);
        chk("midrst.vld",   {31'b0, to_down_vld}, 32'd0);
        chk("midrst.data",  to_down_data, 32'd0);
        chk("midrst.keep",  {28'b0, to_down_keep}, 32'd0);
        rst = 1'b0;
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        beat(8'h77, 1'b0);
        beat(8'h88, 1'b0);
        chk_word("postrst", 32'h88776655, 4'b1111, 1'b0);

        // Reset with a pending word drops it.
        from_up_vld     = 1'b0;
        from_down_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("droprst.vld", {31'b0, to_down_vld}, 32'd0);
        rst = 1'b0;
        from_down_ready = 1'b1;
        step();
        chk("droprst.after", {31'b0, to_down_vld}, 32'd0);
        chk("droprst.data",  to_down_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
